// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating stall-cycle counter for performance monitoring.
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_Valid,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic [XLEN-1:0]  ID_Rs1_Data,
  input  logic [XLEN-1:0]  ID_Rs2_Data,
  input  logic [XLEN-1:0]  ID_Imm,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic [4:0]       ID_Rd,
  input  logic             ID_Use_Rs1,
  input  logic             ID_Use_Rs2,
  input  logic             ID_RegWEN,
  input  logic             ID_MemRead,
  input  logic             ID_MemWrite,
  input  logic [3:0]       ID_ALUOp,
  input  logic [1:0]       ID_Fw_1,
  input  logic [1:0]       ID_Fw_2,
  input  logic             Flush,
  output logic             EX_Valid,
  output logic [XLEN-1:0]  EX_PC,
  output logic [XLEN-1:0]  EX_Rs1_Data,
  output logic [XLEN-1:0]  EX_Rs2_Data,
  output logic [XLEN-1:0]  EX_Imm,
  output logic [4:0]       EX_Rs1,
  output logic [4:0]       EX_Rs2,
  output logic [4:0]       EX_Rd,
  output logic             EX_Use_Rs1,
  output logic             EX_Use_Rs2,
  output logic             EX_RegWEN,
  output logic             EX_MemRead,
  output logic             EX_MemWrite,
  output logic [3:0]       EX_ALUOp,
  output logic [1:0]       EX_Fw_1,
  output logic [1:0]       EX_Fw_2,
  output logic             Stall,
  output logic [CNT_W-1:0] Stall_Cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            regwen;
    logic            memread;
    logic            memwrite;
    logic [3:0]      aluop;
    logic [1:0]      fw_1;
    logic [1:0]      fw_2;
  } ex_t;

  ex_t             ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            lu;
  logic            capture;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign lu = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & ID_Valid &
              ((ID_Use_Rs1 & (ID_Rs1 == ex_q.rd)) | (ID_Use_Rs2 & (ID_Rs2 == ex_q.rd)));

  // A flushed ID instruction is discarded, so it never needs to wait.
  assign Stall   = lu & ~Flush;
  assign capture = ID_Valid & ~Flush & ~lu;

  always_comb begin
    ex_d  = '0;
    cnt_d = Stall ? sat_inc(cnt_q) : cnt_q;
    if (capture) begin
      ex_d.valid    = 1'b1;
      ex_d.pc       = ID_PC;
      ex_d.rs1_data = ID_Rs1_Data;
      ex_d.rs2_data = ID_Rs2_Data;
      ex_d.imm      = ID_Imm;
      ex_d.rs1      = ID_Rs1;
      ex_d.rs2      = ID_Rs2;
      ex_d.rd       = ID_Rd;
      ex_d.use_rs1  = ID_Use_Rs1;
      ex_d.use_rs2  = ID_Use_Rs2;
      ex_d.regwen   = ID_RegWEN;
      ex_d.memread  = ID_MemRead;
      ex_d.memwrite = ID_MemWrite;
      ex_d.aluop    = ID_ALUOp;
      ex_d.fw_1     = ID_Fw_1;
      ex_d.fw_2     = ID_Fw_2;
    end
  end

  // ID -> EX stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign EX_Valid    = ex_q.valid;
  assign EX_PC       = ex_q.pc;
  assign EX_Rs1_Data = ex_q.rs1_data;
  assign EX_Rs2_Data = ex_q.rs2_data;
  assign EX_Imm      = ex_q.imm;
  assign EX_Rs1      = ex_q.rs1;
  assign EX_Rs2      = ex_q.rs2;
  assign EX_Rd       = ex_q.rd;
  assign EX_Use_Rs1  = ex_q.use_rs1;
  assign EX_Use_Rs2  = ex_q.use_rs2;
  assign EX_RegWEN   = ex_q.regwen;
  assign EX_MemRead  = ex_q.memread;
  assign EX_MemWrite = ex_q.memwrite;
  assign EX_ALUOp    = ex_q.aluop;
  assign EX_Fw_1     = ex_q.fw_1;
  assign EX_Fw_2     = ex_q.fw_2;
  assign Stall_Cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: stimulus queues expected EX state and
// Stall values, independent monitors pop and compare them.
module tb_id_ex_stage_reg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            regwen;
    logic            memread;
    logic            memwrite;
    logic [3:0]      aluop;
    logic [1:0]      fw_1;
    logic [1:0]      fw_2;
  } ins_t;

  typedef struct packed {
    ins_t             ex;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Flush = 1'b0;
  ins_t id = '0;
  ins_t ex_obs;
  logic Stall;
  logic [CNT_W-1:0] Stall_Cnt;

  exp_t exq[$];
  logic stq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Valid(id.valid), .ID_PC(id.pc), .ID_Rs1_Data(id.rs1_data),
    .ID_Rs2_Data(id.rs2_data), .ID_Imm(id.imm), .ID_Rs1(id.rs1),
    .ID_Rs2(id.rs2), .ID_Rd(id.rd), .ID_Use_Rs1(id.use_rs1),
    .ID_Use_Rs2(id.use_rs2), .ID_RegWEN(id.regwen), .ID_MemRead(id.memread),
    .ID_MemWrite(id.memwrite), .ID_ALUOp(id.aluop), .ID_Fw_1(id.fw_1),
    .ID_Fw_2(id.fw_2), .Flush(Flush),
    .EX_Valid(ex_obs.valid), .EX_PC(ex_obs.pc), .EX_Rs1_Data(ex_obs.rs1_data),
    .EX_Rs2_Data(ex_obs.rs2_data), .EX_Imm(ex_obs.imm), .EX_Rs1(ex_obs.rs1),
    .EX_Rs2(ex_obs.rs2), .EX_Rd(ex_obs.rd), .EX_Use_Rs1(ex_obs.use_rs1),
    .EX_Use_Rs2(ex_obs.use_rs2), .EX_RegWEN(ex_obs.regwen),
    .EX_MemRead(ex_obs.memread), .EX_MemWrite(ex_obs.memwrite),
    .EX_ALUOp(ex_obs.aluop), .EX_Fw_1(ex_obs.fw_1), .EX_Fw_2(ex_obs.fw_2),
    .Stall(Stall), .Stall_Cnt(Stall_Cnt)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  function automatic ins_t alu(input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [1:0] fw1, input logic [1:0] fw2);
    ins_t r = '0;
    r.valid = 1'b1; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.rs1_data = 32'hA000_0000 | {27'd0, rs1}; r.rs2_data = 32'hB000_0000 | {27'd0, rs2};
    r.use_rs1 = 1'b1; r.use_rs2 = 1'b1; r.regwen = 1'b1; r.aluop = 4'h3;
    r.fw_1 = fw1; r.fw_2 = fw2;
    return r;
  endfunction

  function automatic ins_t lw(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rd);
    ins_t r = '0;
    r.valid = 1'b1; r.pc = pc; r.rs1 = rs1; r.rd = rd; r.imm = 32'd4;
    r.rs1_data = 32'h0000_1000; r.use_rs1 = 1'b1; r.regwen = 1'b1; r.memread = 1'b1;
    return r;
  endfunction

  // Drive one ID instruction before the next rising edge and queue expectations.
  task automatic issue(input ins_t v, input logic fl, input logic exp_stall,
                       input ins_t exp_ex, input int exp_cnt);
    exp_t e;
    @(negedge clk);
    id = v; Flush = fl;
    e.ex = exp_ex; e.cnt = exp_cnt[CNT_W-1:0];
    stq.push_back(exp_stall);
    exq.push_back(e);
  endtask

  initial begin : stall_monitor
    forever begin
      @(negedge clk); #2;
      if (stq.size() > 0) begin
        logic s;
        s = stq.pop_front();
        check("stall", {255'd0, Stall}, {255'd0, s});
      end
    end
  end

  initial begin : ex_monitor
    forever begin
      @(posedge clk); #1;
      if (exq.size() > 0) begin
        exp_t e;
        e = exq.pop_front();
        check("ex_regs", 256'(ex_obs), 256'(e.ex));
        check("stall_cnt", {252'd0, Stall_Cnt}, {252'd0, e.cnt});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    ins_t bub, v;
    bub = '0;

    #2;
    check("reset_ex", 256'(ex_obs), 256'(bub));
    check("reset_stall", {255'd0, Stall}, 256'd0);
    check("reset_cnt", {252'd0, Stall_Cnt}, 256'd0);
    @(negedge clk); rst_n = 1'b1;

    // pass-through, load-use stall, re-presented capture
    v = alu(32'h100, 5'd1, 5'd2, 5'd3, 2'b10, 2'b00);
    issue(v, 1'b0, 1'b0, v, 0);
    v = lw(32'h104, 5'd1, 5'd5);
    issue(v, 1'b0, 1'b0, v, 0);
    v = alu(32'h108, 5'd1, 5'd5, 5'd6, 2'b00, 2'b00);
    issue(v, 1'b0, 1'b1, bub, 1);
    issue(v, 1'b0, 1'b0, v, 1);

    // lw x0 followed by a reader of x0: no hazard
    v = lw(32'h10C, 5'd1, 5'd0);
    issue(v, 1'b0, 1'b0, v, 1);
    v = alu(32'h110, 5'd0, 5'd0, 5'd7, 2'b01, 2'b01);
    issue(v, 1'b0, 1'b0, v, 1);

    // rs1 matches the load but is not used
    v = lw(32'h114, 5'd1, 5'd5);
    issue(v, 1'b0, 1'b0, v, 1);
    v = alu(32'h118, 5'd5, 5'd2, 5'd9, 2'b00, 2'b10);
    v.use_rs1 = 1'b0;
    issue(v, 1'b0, 1'b0, v, 1);

    // invalid ID with live control bits captures as a bubble
    v = lw(32'h11C, 5'd2, 5'd4);
    v.valid = 1'b0; v.memwrite = 1'b1; v.fw_1 = 2'b11;
    issue(v, 1'b0, 1'b0, bub, 1);

    // flush together with a load-use hazard
    v = lw(32'h120, 5'd1, 5'd5);
    issue(v, 1'b0, 1'b0, v, 1);
    v = alu(32'h124, 5'd5, 5'd5, 5'd8, 2'b00, 2'b00);
    issue(v, 1'b1, 1'b0, bub, 1);

    // invalid ID never stalls even when its indices match the load
    v = lw(32'h128, 5'd1, 5'd5);
    issue(v, 1'b0, 1'b0, v, 1);
    v = alu(32'h12C, 5'd5, 5'd5, 5'd8, 2'b00, 2'b00);
    v.valid = 1'b0;
    issue(v, 1'b0, 1'b0, bub, 1);

    // asynchronous reset in the middle of a stall
    v = lw(32'h130, 5'd1, 5'd5);
    issue(v, 1'b0, 1'b0, v, 1);
    @(negedge clk);
    id = alu(32'h134, 5'd5, 5'd2, 5'd10, 2'b00, 2'b00); Flush = 1'b0;
    #1;
    check("midstall_stall_pre", {255'd0, Stall}, 256'd1);
    rst_n = 1'b0;
    #1;
    check("midstall_ex", 256'(ex_obs), 256'(bub));
    check("midstall_stall", {255'd0, Stall}, 256'd0);
    check("midstall_cnt", {252'd0, Stall_Cnt}, 256'd0);
    id = '0;
    @(negedge clk); rst_n = 1'b1;

    // 20 load-use stalls; the 4-bit counter must saturate at 15
    for (int i = 0; i < 20; i++) begin
      v = lw(32'h200 + 32'(8 * i), 5'd1, 5'd5);
      issue(v, 1'b0, 1'b0, v, (i < 15) ? i : 15);
      v = alu(32'h204 + 32'(8 * i), 5'd2, 5'd5, 5'd11, 2'b00, 2'b00);
      issue(v, 1'b0, 1'b1, bub, (i + 1 < 15) ? i + 1 : 15);
    end

    @(negedge clk); id = '0; Flush = 1'b0;
    for (int k = 0; k < 10 && (exq.size() > 0 || stq.size() > 0); k++) @(negedge clk);
    if (exq.size() > 0 || stq.size() > 0) begin
      n_checks++;
      $display("FAIL drain got=%0d exp=0", exq.size() + stq.size());
    end
    #5;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
